// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants for the writeback select stage: load-type
//               codes, FSM state encoding, default source indices and a
//               helper that sizes the memory wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Load-type codes carried on in_load_type
    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    // Stage FSM encoding
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    // Default result-source indices on the flattened source bus
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_LUI = 3;

    // Width needed for a counter that must be able to hold 0..timeout
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational little-endian sub-word extraction and sign/zero
//               extension of memory read data. Byte lanes are chosen by
//               addr_lo; halfwords by addr_lo[1] only, so a misaligned
//               halfword falls back to the aligned one below it.
//               Assumes DATA_W >= 32. Unknown load types pass data through.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword, then extend it according to the load type
    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = data[7:0];
            2'd1:    w_byte = data[15:8];
            2'd2:    w_byte = data[23:16];
            default: w_byte = data[31:24];
        endcase
        w_half = addr_lo[1] ? data[31:16] : data[15:0];

        case (load_type)
            LT_LB:   ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LT_LBU:  ext = {{(DATA_W-8){1'b0}}, w_byte};
            LT_LH:   ext = {{(DATA_W-16){w_half[15]}}, w_half};
            LT_LHU:  ext = {{(DATA_W-16){1'b0}}, w_half};
            default: ext = data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage
// Description : Parametrised MIPS writeback stage. Selects one of NUM_SRC
//               result sources, waits on variable-latency memory reads via
//               mem_rvalid (with timeout), and drives a registered one-cycle
//               register-file write pulse.
//               Build option: define WB_LOAD_EXT_EN to enable sub-word load
//               extraction/extension (LB/LBU/LH/LHU); otherwise memory data is
//               written unmodified and in_load_type/in_addr_lo are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int MEM_SEL = SRC_MEM,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic                      in_reg_write,
    input  logic [ADDR_W-1:0]         in_rd,
    input  logic [2:0]                in_load_type,
    input  logic [1:0]                in_addr_lo,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int                  c_cnt_w    = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0]    c_mem_sel  = SEL_W'(MEM_SEL);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_rd;
    logic               r_reg_write;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;

    logic               w_accept;
    logic               w_is_mem;
    logic               w_sel_ok;
    logic [31:0]        w_sel_ext;
    logic [DATA_W-1:0]  w_src;
    logic [DATA_W-1:0]  w_mem_data;
    logic               w_do_write;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;

    assign in_ready    = (r_state == ST_IDLE) && !rst;
    assign busy        = (r_state == ST_WAIT_MEM);
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign err_timeout = r_err;

    assign w_accept  = in_valid && in_ready;
    assign w_is_mem  = (in_sel == c_mem_sel);
    assign w_sel_ext = 32'(in_sel);
    assign w_sel_ok  = (w_sel_ext < 32'(NUM_SRC));

    // Source mux; out-of-range selects yield zero and are never written
    always_comb begin
        w_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_sel_ext == 32'(k)) begin
                w_src = in_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [2:0] r_load_type;
    logic [1:0] r_addr_lo;
    logic [2:0] w_ext_type;
    logic [1:0] w_ext_addr;

    // Same-cycle completions use the live request fields, waits use the captured ones
    assign w_ext_type = (r_state == ST_WAIT_MEM) ? r_load_type : in_load_type;
    assign w_ext_addr = (r_state == ST_WAIT_MEM) ? r_addr_lo   : in_addr_lo;

    load_extend #(
        .DATA_W   (DATA_W)
    ) u_load_extend (
        .load_type (w_ext_type),
        .addr_lo   (w_ext_addr),
        .data      (mem_rdata),
        .ext       (w_mem_data)
    );

    // Capture the sub-word request fields when a load has to wait
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_type <= LT_LW;
            r_addr_lo   <= 2'd0;
        end else if (w_accept && w_is_mem && !mem_rvalid) begin
            r_load_type <= in_load_type;
            r_addr_lo   <= in_addr_lo;
        end
    end
`else
    logic w_unused_ld;
    assign w_unused_ld = ^{in_load_type, in_addr_lo};
    assign w_mem_data  = mem_rdata;
`endif

    // Decide whether this cycle completes a register-file write, and with what
    always_comb begin
        w_do_write = 1'b0;
        w_wr_addr  = in_rd;
        w_wr_data  = w_src;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mem) begin
                        if (mem_rvalid) begin
                            w_do_write = in_reg_write && (in_rd != '0);
                            w_wr_data  = w_mem_data;
                        end
                    end else if (w_sel_ok) begin
                        w_do_write = in_reg_write && (in_rd != '0);
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_do_write = r_reg_write && (r_rd != '0);
                    w_wr_addr  = r_rd;
                    w_wr_data  = w_mem_data;
                end
            end
            default: ;
        endcase
    end

    // Output register: one-cycle write pulse, address/data held between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_do_write;
            if (w_do_write) begin
                r_waddr <= w_wr_addr;
                r_wdata <= w_wr_data;
            end
        end
    end

    // Stage FSM: park in WAIT_MEM on an unanswered load until data or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mem && !mem_rvalid) begin
                        r_rd        <= in_rd;
                        r_reg_write <= in_reg_write;
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_select_stage
// Description : Directed self-checking bench for wb_select_stage, built with
//               NUM_SRC=3 and TIMEOUT=4 so bad-select and timeout paths are
//               short. Sub-word expectations follow WB_LOAD_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;
    import wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_SRC*DATA_W-1:0] in_src_data;
    logic                      in_reg_write;
    logic [ADDR_W-1:0]         in_rd;
    logic [2:0]                in_load_type;
    logic [1:0]                in_addr_lo;
    logic                      mem_rvalid;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      busy;
    logic                      err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_select_stage #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .MEM_SEL (1),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_src_data  (in_src_data),
        .in_reg_write (in_reg_write),
        .in_rd        (in_rd),
        .in_load_type (in_load_type),
        .in_addr_lo   (in_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_src_data = '0;
        in_reg_write = 1'b0; in_rd = '0; in_load_type = LT_LW;
        in_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", rf_we); end
        n_tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wr: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        n_tests++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got busy=%0b err=%0b want 0/0", busy, err_timeout); end
        rst = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rel: got %0b want 1", in_ready); end
    endtask

    task automatic test_alu();
        in_src_data[0 +: 32] = 32'h0000_1234;
        in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd8; in_reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %0b want 1", rf_we); end
        n_tests++; if (rf_waddr !== 5'd8) begin n_fail++; $display("FAIL alu_waddr: got %0d want 8", rf_waddr); end
        n_tests++; if (rf_wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_wdata: got %h want 00001234", rf_wdata); end
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_pulse: got %0b want 0", rf_we); end
        n_tests++; if (rf_wdata !== 32'h0000_1234 || rf_waddr !== 5'd8) begin n_fail++; $display("FAIL alu_hold: got %0d/%h want 8/00001234", rf_waddr, rf_wdata); end
    endtask

    task automatic test_back_to_back();
        in_src_data[64 +: 32] = 32'hAAAA_0002;
        in_src_data[0 +: 32]  = 32'h0000_5555;
        in_valid = 1'b1; in_sel = 2'd2; in_rd = 5'd3;
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA_0002) begin n_fail++; $display("FAIL b2b_first: got we=%0b %0d/%h want 1 3/aaaa0002", rf_we, rf_waddr, rf_wdata); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", in_ready); end
        in_sel = 2'd0; in_rd = 5'd4;
        tick();
        in_valid = 1'b0;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h0000_5555) begin n_fail++; $display("FAIL b2b_second: got we=%0b %0d/%h want 1 4/00005555", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %0b want 0", rf_we); end
    endtask

    task automatic test_mem_wait();
        in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd9; in_reg_write = 1'b1;
        in_load_type = LT_LW; in_addr_lo = 2'd0; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL mem_wait%0d: got busy=%0b ready=%0b we=%0b want 1/0/0", i, busy, in_ready, rf_we); end
            if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
            tick();
        end
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mem_write: got we=%0b %0d/%h want 1 9/deadbeef", rf_we, rf_waddr, rf_wdata); end
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mem_idle: got busy=%0b ready=%0b want 0/1", busy, in_ready); end
    endtask

    task automatic test_subword();
        logic [2:0]  lts [4] = '{LT_LBU, LT_LH, LT_LH, LT_LHU};
        logic [1:0]  ads [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
`ifdef WB_LOAD_EXT_EN
        logic [31:0] exp_wait = 32'hFFFF_FFFF;
        logic [31:0] exps [4] = '{32'h0000_0080, 32'h0000_1280, 32'hFFFF_FF7F, 32'h0000_FF7F};
`else
        logic [31:0] exp_wait = 32'h1280_FF7F;
        logic [31:0] exps [4] = '{32'h1280_FF7F, 32'h1280_FF7F, 32'h1280_FF7F, 32'h1280_FF7F};
`endif
        // LB at offset 1 through the wait path; live fields change during the wait
        in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd12; in_reg_write = 1'b1;
        in_load_type = LT_LB; in_addr_lo = 2'd1; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0; in_load_type = LT_LW; in_addr_lo = 2'd0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1280_FF7F;
        tick();
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== exp_wait) begin n_fail++; $display("FAIL sub_lb_wait: got we=%0b %0d/%h want 1 12/%h", rf_we, rf_waddr, rf_wdata, exp_wait); end
        // Same-cycle completions
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_rd = 5'(13 + i); in_load_type = lts[i]; in_addr_lo = ads[i];
            mem_rvalid = 1'b1;
            tick();
            in_valid = 1'b0; mem_rvalid = 1'b0;
            n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'(13 + i) || rf_wdata !== exps[i] || busy !== 1'b0) begin n_fail++; $display("FAIL sub_%0d: got we=%0b %0d/%h busy=%0b want 1 %0d/%h 0", i, rf_we, rf_waddr, rf_wdata, busy, 13 + i, exps[i]); end
        end
        in_load_type = LT_LW; in_addr_lo = 2'd0;
        tick();
    endtask

    task automatic test_rd0_badsel();
        in_valid = 1'b1; in_sel = 2'd2; in_rd = 5'd0; in_reg_write = 1'b1;
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %0b want 0", rf_we); end
        in_sel = 2'd3; in_rd = 5'd5;
        tick();
        n_tests++; if (rf_we !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL badsel: got we=%0b ready=%0b busy=%0b want 0/1/0", rf_we, in_ready, busy); end
        n_tests++; if (rf_waddr !== 5'd16) begin n_fail++; $display("FAIL badsel_hold: got waddr=%0d want 16", rf_waddr); end
        // Memory load to rd 0 still waits for its data
        in_sel = 2'd1; in_rd = 5'd0; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd0_mem_busy: got %0b want 1", busy); end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd0_mem_done: got we=%0b busy=%0b want 0/0", rf_we, busy); end
        // Stray mem_rvalid in IDLE
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid: got %0b want 0", rf_we); end
    endtask

    task automatic test_timeout();
        in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd10; in_reg_write = 1'b1; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got busy=%0b err=%0b want 1/0", i, busy, err_timeout); end
            tick();
        end
        n_tests++; if (err_timeout !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL to_fire: got err=%0b busy=%0b we=%0b ready=%0b want 1/0/0/1", err_timeout, busy, rf_we, in_ready); end
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b0 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_late: got we=%0b err=%0b want 0/1", rf_we, err_timeout); end
        in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd7;
        tick();
        in_valid = 1'b0;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got we=%0b waddr=%0d err=%0b want 1/7/1", rf_we, rf_waddr, err_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd11; in_reg_write = 1'b1; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmw_busy: got %0b want 1", busy); end
        rst = 1'b1;
        tick();
        n_tests++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || busy !== 1'b0 || err_timeout !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmw_rst: got we=%0b %0d/%h busy=%0b err=%0b ready=%0b want all 0", rf_we, rf_waddr, rf_wdata, busy, err_timeout, in_ready); end
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        n_tests++; if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_after: got we=%0b busy=%0b ready=%0b want 0/0/1", rf_we, busy, in_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_mem_wait();
        test_subword();
        test_rd0_badsel();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised writeback stage for the MIPS datapath. It replaces the 2:1 memory/ALU writeback select.
- Selects one of NUM_SRC result sources, such as ALU, memory, PC+4 (JAL) and LUI immediate.
- Waits on variable-latency memory reads through a ready/valid handshake and extends sub-word loads.
- Presents a registered, single-cycle register-file write pulse.

Parameters:
- DATA_W, 32, datapath width.
- NUM_SRC, 4, number of selectable result sources.
- SEL_W, 2, width of the source select; must satisfy 2^SEL_W >= NUM_SRC.
- MEM_SEL, 1, select value that denotes memory read data.
- ADDR_W, 5, register-file address width.
- TIMEOUT, 255, maximum number of cycles to wait for mem_rvalid before flagging an error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  stage can accept a request.
- in_sel  in  SEL_W  source select.
- in_src_data  in  NUM_SRC*DATA_W  flattened source bus; slice k is source k. Slice MEM_SEL is unused.
- in_reg_write  in  1  request writes the register file.
- in_rd  in  ADDR_W  destination register.
- in_load_type  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU.
- in_addr_lo  in  2  byte offset of the load address.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- rf_we  out  1  register-file write enable (one-cycle pulse).
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- busy  out  1  stage is in WAIT_MEM.
- err_timeout  out  1  sticky memory-timeout flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, err_timeout=0, state=IDLE, wait counter=0. in_ready=0 while rst=1.
- in_ready: combinational, equal to (state==IDLE && !rst).
- A request is accepted when in_valid && in_ready.
- IDLE, non-memory accept (in_sel!=MEM_SEL):
  - Next cycle: rf_wdata = slice in_sel, rf_waddr = in_rd, rf_we = in_reg_write && in_rd!=0. Latency is 1.
  - State stays IDLE, so back-to-back accepts every cycle are legal.
- IDLE, memory accept, mem_rvalid=1 in the same cycle: handled as the non-memory case using extended mem_rdata. Latency 1.
- IDLE, memory accept, mem_rvalid=0:
  - Capture rd, reg_write, load_type and addr_lo; clear the wait counter; go to WAIT_MEM.
- WAIT_MEM:
  - busy=1 and in_ready=0.
  - Each cycle without mem_rvalid, the counter increments.
  - On mem_rvalid: rf_wdata = extended mem_rdata, rf_waddr = captured rd, rf_we = captured reg_write && rd!=0, all on the next cycle; then return to IDLE.
  - When the counter reaches TIMEOUT with no mem_rvalid: set err_timeout (sticky until rst), write nothing, return to IDLE.
- mem_rvalid in IDLE with no memory accept that cycle: ignored, no write.
- in_sel >= NUM_SRC: request consumed, rf_we=0, no state change.
- rd==0: write suppressed. A memory request with rd==0 still waits for mem_rvalid.
- rf_we is high for exactly one cycle per completed write. rf_waddr and rf_wdata hold their values while rf_we=0.
- rst asserted mid-WAIT_MEM: the pending load is abandoned with no write. A mem_rvalid arriving after reset is ignored.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined:
  - Memory data is extracted little-endian by in_addr_lo.
  - LB/LBU take byte addr_lo, sign- or zero-extended to DATA_W.
  - LH/LHU take the halfword at addr_lo[1], sign- or zero-extended.
  - LW passes the word through.
  - Misaligned halfwords (addr_lo[0]=1) are treated as addr_lo&2'b10.
- Undefined: in_load_type and in_addr_lo are ignored; memory data is written unmodified.

Decomposition:
- Package wb_pkg:
  - load-type codes LT_LW/LT_LB/LT_LBU/LT_LH/LT_LHU;
  - state encoding ST_IDLE/ST_WAIT_MEM;
  - default source indices SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_LUI=3.
- One combinational sub-module, load_extend (load_type, addr_lo, data -> extended data), instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- ALU write: in_sel=0, src0=0x0000_1234, rd=8, reg_write=1 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x0000_1234; pulse lasts 1 cycle.
- Memory wait: in_sel=1, rd=9, mem_rvalid asserted 3 cycles later with 0xDEAD_BEEF -> in_ready=0 and busy=1 for 3 cycles; rf_wdata=0xDEAD_BEEF one cycle after mem_rvalid; back to IDLE.
- Sub-word load (WB_LOAD_EXT_EN):
  - mem_rdata=0x1280_FF7F, LB with addr_lo=1 -> 0xFFFF_FFFF;
  - LBU with addr_lo=2 -> 0x0000_0080;
  - LH with addr_lo=2 -> 0x0000_1280.
- rd=0 and bad select: rd=0 with in_sel=2 -> rf_we stays 0; in_sel=3 with NUM_SRC=3 -> no write, in_ready stays 1.
- Timeout: TIMEOUT=4, memory request with no mem_rvalid -> err_timeout=1 after 4 wait cycles, no write; a later mem_rvalid is ignored and err_timeout stays 1 until rst.
- Reset mid-wait: rst during WAIT_MEM, then mem_rvalid -> no rf_we; all outputs 0 after reset; in_ready=1 once rst drops.
